// File: rtl/pool_pkg.sv
// Shared definitions for the pooling engine: FSM states, pooling mode
// constants and the compile-time helpers that size the output map.
package pool_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      DRAIN,
      WRITE,
      NEXT,
      DONE
   } pool_state_t;

   localparam int POOL_MAX = 0;
   localparam int POOL_AVG = 1;

   // Ceiling log2, evaluated at elaboration time.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < value) result = i + 1;
      return result;
   endfunction

   // Output rows: trailing rows not covered by a full window are dropped.
   function automatic int out_h(input int in_h, input int k, input int stride);
      return (in_h - k) / stride + 1;
   endfunction

   // Output columns: trailing columns not covered by a full window are dropped.
   function automatic int out_w(input int in_w, input int k, input int stride);
      return (in_w - k) / stride + 1;
   endfunction

endpackage

// File: rtl/pool_window_acc.sv
// Per-window accumulator: signed running max or widened running sum.
// acc_clear with acc_en loads the first sample of a window; acc_en alone
// folds in the next sample. result is the pooled value of what has been
// accumulated so far. Optional fused ReLU under `define POOL_RELU_EN.
module pool_window_acc
   import pool_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int POOL_K    = 2,
   parameter int POOL_MODE = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              acc_en,
   input  logic              acc_clear,
   input  logic [DATA_W-1:0] sample,
   output logic [DATA_W-1:0] result
);

   // The sum needs 2*log2(K) guard bits so K*K samples cannot overflow.
   localparam int SHIFT = 2 * clog2(POOL_K);
   localparam int SUM_W = DATA_W + SHIFT;

   logic signed [SUM_W-1:0] acc;
   logic signed [SUM_W-1:0] sample_ext;
   logic [DATA_W-1:0]       pooled;

   assign sample_ext = {{SHIFT{sample[DATA_W-1]}}, sample};

   // Load on the first sample, then sum (average) or keep the signed max.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (acc_en) begin
         if (acc_clear)
            acc <= sample_ext;
         else if (POOL_MODE == POOL_AVG)
            acc <= acc + sample_ext;
         else if (sample_ext > acc)
            acc <= sample_ext;
      end
   end

   // Average: taking the bits above SHIFT is the arithmetic shift (floor)
   // followed by truncation to DATA_W. Max: the value already fits DATA_W.
   always_comb begin
      pooled = (POOL_MODE == POOL_AVG) ? acc[SUM_W-1:SHIFT] : acc[DATA_W-1:0];
`ifdef POOL_RELU_EN
      if (pooled[DATA_W-1]) pooled = '0;
`endif
      result = pooled;
   end

endmodule

// File: rtl/pool_layer_engine.sv
// KxK max/average pooling engine over a multi-channel feature map.
// A run starts on a 0->1 edge of layer_enable; dropping layer_enable aborts.
// Each window: K*K reads, one drain cycle for the last read, one write, one
// anchor-advance cycle. Fused ReLU on results when POOL_RELU_EN is defined.
// Read port: rd_data is valid exactly one cycle after rd_en.
module pool_layer_engine
   import pool_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16,
   parameter int IN_H      = 35,
   parameter int IN_W      = 35,
   parameter int CHANNELS  = 1,
   parameter int POOL_K    = 2,
   parameter int STRIDE    = 2,
   parameter int POOL_MODE = 0,
   parameter int IN_BASE   = 0,
   parameter int OUT_BASE  = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              layer_enable,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              bus_wr_en,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_data,
   output logic [15:0]       anchor_height,
   output logic [15:0]       anchor_width,
   output logic              busy,
   output logic              done
);

   localparam int OUT_H  = out_h(IN_H, POOL_K, STRIDE);
   localparam int OUT_W  = out_w(IN_W, POOL_K, STRIDE);
   localparam int WIN    = POOL_K * POOL_K;
   localparam int PLANE  = IN_H * IN_W;
   localparam int KW     = clog2(POOL_K) + 1;
   localparam int WIDX_W = clog2(WIN) + 1;

   localparam logic [KW-1:0]     K_LAST   = KW'(POOL_K - 1);
   localparam logic [WIDX_W-1:0] WIN_LAST = WIDX_W'(WIN - 1);
   localparam logic [15:0]       AW_LAST  = 16'((OUT_W - 1) * STRIDE);
   localparam logic [15:0]       AH_LAST  = 16'((OUT_H - 1) * STRIDE);
   localparam logic [15:0]       C_LAST   = 16'(CHANNELS - 1);

   pool_state_t       state;
   logic              en_q;
   logic [15:0]       ch, ah, aw;
   logic [KW-1:0]     ky, kx, nky, nkx;
   logic [WIDX_W-1:0] win_idx;
   logic [ADDR_W-1:0] out_idx;
   logic [15:0]       n_ch, n_ah, n_aw;
   logic              last_win;
   logic              acc_en, acc_clear;
   logic [DATA_W-1:0] acc_result;

   assign anchor_height = ah;
   assign anchor_width  = aw;

   function automatic logic [ADDR_W-1:0] addr_of(input logic [15:0] cc, input logic [15:0] hh,
                                                 input logic [15:0] ww, input logic [KW-1:0] yy,
                                                 input logic [KW-1:0] xx);
      return ADDR_W'(32'(IN_BASE) + 32'(cc) * 32'(PLANE) + (32'(hh) + 32'(yy)) * 32'(IN_W)
                     + 32'(ww) + 32'(xx));
   endfunction

   // Next in-window offset, raster order: kx inner, ky outer.
   always_comb begin
      nkx = kx + KW'(1);
      nky = ky;
      if (kx == K_LAST) begin
         nkx = '0;
         nky = ky + KW'(1);
      end
   end

   // Next anchor: column first, then row, then channel.
   always_comb begin
      n_aw     = aw + 16'(STRIDE);
      n_ah     = ah;
      n_ch     = ch;
      last_win = 1'b0;
      if (aw == AW_LAST) begin
         n_aw = '0;
         n_ah = ah + 16'(STRIDE);
         if (ah == AH_LAST) begin
            n_ah = '0;
            n_ch = ch + 16'd1;
            if (ch == C_LAST) last_win = 1'b1;
         end
      end
   end

   // Read j's data arrives in READ cycle j+1; the last one lands in DRAIN.
   assign acc_en    = ((state == READ) && (win_idx != '0)) || (state == DRAIN);
   assign acc_clear = (state == READ) && (win_idx == WIDX_W'(1));

   pool_window_acc #(
      .DATA_W   (DATA_W),
      .POOL_K   (POOL_K),
      .POOL_MODE(POOL_MODE)
   ) u_acc (
      .clk      (clk),
      .rst_n    (rst_n),
      .acc_en   (acc_en),
      .acc_clear(acc_clear),
      .sample   (rd_data),
      .result   (acc_result)
   );

   // Control FSM with registered bus strobes; abort overrides the state step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         en_q      <= 1'b1;  // a level already high at reset release is not a start
         ch        <= '0;
         ah        <= '0;
         aw        <= '0;
         ky        <= '0;
         kx        <= '0;
         win_idx   <= '0;
         out_idx   <= '0;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         bus_wr_en <= 1'b0;
         bus_addr  <= '0;
         bus_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         en_q <= layer_enable;
         case (state)
            IDLE: begin
               if (layer_enable && !en_q) begin
                  state   <= READ;
                  busy    <= 1'b1;
                  ch      <= '0;
                  ah      <= '0;
                  aw      <= '0;
                  ky      <= '0;
                  kx      <= '0;
                  win_idx <= '0;
                  out_idx <= '0;
                  rd_en   <= 1'b1;
                  rd_addr <= addr_of(16'd0, 16'd0, 16'd0, '0, '0);
               end
            end
            READ: begin
               if (win_idx == WIN_LAST) begin
                  state <= DRAIN;
                  rd_en <= 1'b0;
               end else begin
                  rd_en   <= 1'b1;
                  rd_addr <= addr_of(ch, ah, aw, nky, nkx);
                  ky      <= nky;
                  kx      <= nkx;
                  win_idx <= win_idx + WIDX_W'(1);
               end
            end
            DRAIN: state <= WRITE;
            WRITE: begin
               bus_wr_en <= 1'b1;
               bus_addr  <= ADDR_W'(OUT_BASE) + out_idx;
               bus_data  <= acc_result;
               out_idx   <= out_idx + ADDR_W'(1);
               state     <= NEXT;
            end
            NEXT: begin
               bus_wr_en <= 1'b0;
               ch        <= n_ch;
               ah        <= n_ah;
               aw        <= n_aw;
               ky        <= '0;
               kx        <= '0;
               win_idx   <= '0;
               if (last_win) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state   <= READ;
                  rd_en   <= 1'b1;
                  rd_addr <= addr_of(n_ch, n_ah, n_aw, '0, '0);
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if ((state inside {READ, DRAIN, WRITE, NEXT}) && !layer_enable) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rd_en     <= 1'b0;
            bus_wr_en <= 1'b0;
            done      <= 1'b0;
         end
      end
   end

endmodule
